// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared types for the multi-channel counter bank.
//   cnt_mode_e : counting mode shared by all channels
//      CM_WRAP    - roll over at the terminal value
//      CM_SAT     - stick at the terminal value
//      CM_ONESHOT - saturate, then freeze with a sticky done flag
//      CM_RSVD    - unused encoding; behaves as CM_WRAP
// ---------------------------------------------------------------------------
package counter_pkg;

   typedef enum logic [1:0] {
      CM_WRAP    = 2'd0,
      CM_SAT     = 2'd1,
      CM_ONESHOT = 2'd2,
      CM_RSVD    = 2'd3
   } cnt_mode_e;

endpackage

// File: rtl/counter_mc_chan.sv
// ---------------------------------------------------------------------------
// counter_mc_chan
//   One channel of the counter bank: count register, terminal-count pulse
//   and one-shot done flag, plus the next-state logic for them.
//   Ports:
//      clk   in   1      clock, all state on posedge
//      rst   in   1      synchronous reset, active-high
//      cen   in   1      count enable
//      dir   in   1      0 = count up, 1 = count down
//      wen   in   1      parallel load strobe (beats cen)
//      dat   in   WIDTH  parallel load value
//      mode  in   2      counting mode (see cnt_mode_e)
//      lim   in   WIDTH  limit; terminal value when counting up
//      cnt   out  WIDTH  registered count
//      tc    out  1      registered one-cycle terminal-count pulse
//      done  out  1      sticky completion flag in one-shot mode
// ---------------------------------------------------------------------------
module counter_mc_chan
   import counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic             dir,
   input  logic             wen,
   input  logic [WIDTH-1:0] dat,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] lim,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             done
);

   cnt_mode_e        cur_mode;
   logic             saturating;
   logic             frozen;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] stepped;
   logic [WIDTH-1:0] cnt_next;
   logic             tc_next;
   logic             done_next;

   // Decode the shared mode. One-shot counts like saturate until it has
   // completed, after which the channel ignores cen until it is reloaded.
   always_comb begin
      cur_mode   = cnt_mode_e'(mode);
      saturating = (cur_mode == CM_SAT) || (cur_mode == CM_ONESHOT);
      frozen     = (cur_mode == CM_ONESHOT) && done;
      term       = dir ? '0 : lim;
   end

   // Value the count would take if it stepped this cycle. Counting up from
   // anywhere at or above the limit is treated as having reached it, so a
   // channel left above a newly lowered limit recovers on its next step.
   always_comb begin
      stepped = cnt;
      if (!dir) begin
         if (cnt >= lim) begin
            stepped = saturating ? lim : '0;
         end else begin
            stepped = cnt + 1'b1;
         end
      end else begin
         if (cnt == '0) begin
            stepped = saturating ? '0 : lim;
         end else begin
            stepped = cnt - 1'b1;
         end
      end
   end

   // Next-state selection: load beats count. The terminal pulse fires only
   // when a real step moves the count onto the terminal value, so holding at
   // the terminal or loading it never pulses. In one-shot mode that same
   // event is what completes the channel.
   always_comb begin
      cnt_next  = cnt;
      tc_next   = 1'b0;
      done_next = done;
      if (wen) begin
         cnt_next  = dat;
         done_next = 1'b0;
      end else if (cen && !frozen) begin
         cnt_next = stepped;
         tc_next  = (stepped == term) && (cnt != term);
         if (cur_mode == CM_ONESHOT && tc_next) begin
            done_next = 1'b1;
         end
      end
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tc   <= 1'b0;
         done <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         tc   <= tc_next;
         done <= done_next;
      end
   end

endmodule

// File: rtl/counter_mc.sv
// ---------------------------------------------------------------------------
// counter_mc
//   Bank of NCH independent up/down counters sharing a limit and a mode.
//   Used as a timer / event-count bank.
//   Ports:
//      clk   in   1          clock, all state on posedge
//      rst   in   1          synchronous reset, active-high
//      cen   in   NCH        per-channel count enable
//      dir   in   NCH        per-channel direction (0 up, 1 down)
//      wen   in   NCH        per-channel load strobe
//      dat   in   NCH*WIDTH  load data, channel i at [i*WIDTH +: WIDTH]
//      mode  in   2          0 wrap, 1 saturate, 2 one-shot, 3 as wrap
//      lim   in   WIDTH      shared limit
//      cnt   out  NCH*WIDTH  registered counts, channel i at [i*WIDTH +: WIDTH]
//      tc    out  NCH        registered terminal-count pulses
//      done  out  NCH        one-shot completion flags
// ---------------------------------------------------------------------------
module counter_mc #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       cen,
   input  logic [NCH-1:0]       dir,
   input  logic [NCH-1:0]       wen,
   input  logic [NCH*WIDTH-1:0] dat,
   input  logic [1:0]           mode,
   input  logic [WIDTH-1:0]     lim,
   output logic [NCH*WIDTH-1:0] cnt,
   output logic [NCH-1:0]       tc,
   output logic [NCH-1:0]       done
);

   // Channels share only lim and mode; everything else is per channel.
   for (genvar i = 0; i < NCH; i++) begin : g_chan
      counter_mc_chan #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clk  (clk),
         .rst  (rst),
         .cen  (cen[i]),
         .dir  (dir[i]),
         .wen  (wen[i]),
         .dat  (dat[i*WIDTH +: WIDTH]),
         .mode (mode),
         .lim  (lim),
         .cnt  (cnt[i*WIDTH +: WIDTH]),
         .tc   (tc[i]),
         .done (done[i])
      );
   end

endmodule
